// File: rtl/iq_cic_decimator.sv
// Dual-channel (I/Q) N-stage CIC decimator with a runtime power-of-two rate,
// DC gain normalisation and round/saturate to the output width.
module iq_cic_decimator #(
  parameter int unsigned INPUT_WIDTH   = 12,
  parameter int unsigned OUTPUT_WIDTH  = 12,
  parameter int unsigned N_STAGES      = 4,
  parameter int unsigned MAX_RATE_LOG2 = 6,
  parameter int unsigned RATE_W        = 3
) (
  input  logic                           clk_in,
  input  logic                           RST,
  input  logic                           in_valid,
  input  logic [RATE_W-1:0]              rate_log2,
  input  logic signed [INPUT_WIDTH-1:0]  I_IN,
  input  logic signed [INPUT_WIDTH-1:0]  Q_IN,
  output logic signed [OUTPUT_WIDTH-1:0] I_OUT,
  output logic signed [OUTPUT_WIDTH-1:0] Q_OUT,
  output logic                           out_valid,
  output logic [RATE_W-1:0]              rate_active
);

  localparam int unsigned ACC_WIDTH = INPUT_WIDTH + N_STAGES * MAX_RATE_LOG2;
  localparam int unsigned CNT_W     = MAX_RATE_LOG2;
  localparam int unsigned SH_W      = $clog2(N_STAGES * MAX_RATE_LOG2 + 1);
  localparam int unsigned DROP      = (OUTPUT_WIDTH < INPUT_WIDTH) ? INPUT_WIDTH - OUTPUT_WIDTH : 0;
  localparam int unsigned PAD       = (OUTPUT_WIDTH >= INPUT_WIDTH) ? OUTPUT_WIDTH - INPUT_WIDTH : 0;
  localparam int unsigned RND       = (1 << DROP) >> 1;
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    ACC_WIDTH'((64'(1) << (OUTPUT_WIDTH - 1)) - 64'(1));
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  logic [RATE_W-1:0]           r_rate;
  logic [CNT_W-1:0]            r_cnt;
  logic signed [ACC_WIDTH-1:0] r_int_i [N_STAGES];
  logic signed [ACC_WIDTH-1:0] r_int_q [N_STAGES];
  logic signed [ACC_WIDTH-1:0] r_ci    [N_STAGES];
  logic signed [ACC_WIDTH-1:0] r_cq    [N_STAGES];
  logic signed [ACC_WIDTH-1:0] r_di    [N_STAGES];
  logic signed [ACC_WIDTH-1:0] r_dq    [N_STAGES];
  logic [SH_W-1:0]             r_csh   [N_STAGES];
  logic [N_STAGES-1:0]         r_cv;
  logic signed [OUTPUT_WIDTH-1:0] r_i_out;
  logic signed [OUTPUT_WIDTH-1:0] r_q_out;
  logic                        r_out_valid;

  logic [RATE_W-1:0]           w_rate_clamped;
  logic [CNT_W-1:0]            w_cnt_last;
  logic                        w_strobe;
  logic signed [ACC_WIDTH-1:0] w_int_i [N_STAGES];
  logic signed [ACC_WIDTH-1:0] w_int_q [N_STAGES];
  logic signed [ACC_WIDTH-1:0] w_cin_i [N_STAGES];
  logic signed [ACC_WIDTH-1:0] w_cin_q [N_STAGES];
  logic [SH_W-1:0]             w_sh_in [N_STAGES];
  logic [N_STAGES-1:0]         w_cv_in;

  // Gain normalise, then round half-up / zero-pad and saturate to the output width.
  function automatic logic signed [OUTPUT_WIDTH-1:0] f_scale(
    input logic signed [ACC_WIDTH-1:0] v,
    input logic        [SH_W-1:0]      sh
  );
    logic signed [ACC_WIDTH-1:0] s;
    s = v >>> sh;
    s = (s + $signed(ACC_WIDTH'(RND))) >>> DROP;
    s = s <<< PAD;
    if (s > SAT_MAX)      s = SAT_MAX;
    else if (s < SAT_MIN) s = SAT_MIN;
    return OUTPUT_WIDTH'(s);
  endfunction

  always_comb begin
    w_rate_clamped = rate_log2;
    if (rate_log2 == '0)                      w_rate_clamped = RATE_W'(1);
    else if (32'(rate_log2) > MAX_RATE_LOG2)  w_rate_clamped = RATE_W'(MAX_RATE_LOG2);
  end

  assign w_cnt_last = CNT_W'((64'(1) << r_rate) - 64'(1));
  assign w_strobe   = in_valid && (r_cnt == w_cnt_last);

  // Full cascade next-state so the strobe captures the frame's last sample.
  always_comb begin
    logic signed [ACC_WIDTH-1:0] v_acc_i;
    logic signed [ACC_WIDTH-1:0] v_acc_q;
    v_acc_i = {{(ACC_WIDTH-INPUT_WIDTH){I_IN[INPUT_WIDTH-1]}}, I_IN};
    v_acc_q = {{(ACC_WIDTH-INPUT_WIDTH){Q_IN[INPUT_WIDTH-1]}}, Q_IN};
    for (int k = 0; k < N_STAGES; k++) begin
      v_acc_i    = v_acc_i + r_int_i[k];
      v_acc_q    = v_acc_q + r_int_q[k];
      w_int_i[k] = v_acc_i;
      w_int_q[k] = v_acc_q;
    end
  end

  // Comb stage inputs; the shift amount travels with each decimated sample.
  always_comb begin
    w_cin_i[0] = w_int_i[N_STAGES-1];
    w_cin_q[0] = w_int_q[N_STAGES-1];
    w_cv_in[0] = w_strobe;
    w_sh_in[0] = SH_W'(N_STAGES * 32'(r_rate));
    for (int k = 1; k < N_STAGES; k++) begin
      w_cin_i[k] = r_ci[k-1];
      w_cin_q[k] = r_cq[k-1];
      w_cv_in[k] = r_cv[k-1];
      w_sh_in[k] = r_csh[k-1];
    end
  end

  always_ff @(posedge clk_in) begin
    if (RST) begin
      r_rate      <= w_rate_clamped;
      r_cnt       <= '0;
      r_cv        <= '0;
      r_out_valid <= 1'b0;
      r_i_out     <= '0;
      r_q_out     <= '0;
      for (int k = 0; k < N_STAGES; k++) begin
        r_int_i[k] <= '0;
        r_int_q[k] <= '0;
        r_ci[k]    <= '0;
        r_cq[k]    <= '0;
        r_di[k]    <= '0;
        r_dq[k]    <= '0;
        r_csh[k]   <= '0;
      end
    end else begin
      if (in_valid) begin
        for (int k = 0; k < N_STAGES; k++) begin
          r_int_i[k] <= w_int_i[k];
          r_int_q[k] <= w_int_q[k];
        end
        r_cnt <= w_strobe ? '0 : r_cnt + CNT_W'(1);
        if (w_strobe) r_rate <= w_rate_clamped;
      end
      r_cv <= w_cv_in;
      for (int k = 0; k < N_STAGES; k++) begin
        if (w_cv_in[k]) begin
          r_ci[k]  <= w_cin_i[k] - r_di[k];
          r_cq[k]  <= w_cin_q[k] - r_dq[k];
          r_di[k]  <= w_cin_i[k];
          r_dq[k]  <= w_cin_q[k];
          r_csh[k] <= w_sh_in[k];
        end
      end
      r_out_valid <= r_cv[N_STAGES-1];
      if (r_cv[N_STAGES-1]) begin
        r_i_out <= f_scale(r_ci[N_STAGES-1], r_csh[N_STAGES-1]);
        r_q_out <= f_scale(r_cq[N_STAGES-1], r_csh[N_STAGES-1]);
      end
    end
  end

  assign I_OUT       = r_i_out;
  assign Q_OUT       = r_q_out;
  assign out_valid   = r_out_valid;
  assign rate_active = r_rate;

endmodule

// File: tb/tb_iq_cic_decimator.sv
// Bench for iq_cic_decimator: DC vector table, hand corner sequences and random
// stimulus, all checked against an Nth-sum / Nth-difference reference model.
module tb_iq_cic_decimator;

  localparam int N    = 4;
  localparam int IW   = 12;
  localparam int ACCW = 12 + 4 * 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vld = 1'b0;
  logic [2:0] rate = 3'd3;
  logic signed [11:0] i_in = '0;
  logic signed [11:0] q_in = '0;
  logic signed [11:0] i_out, q_out;
  logic signed [9:0]  i_out10, q_out10;
  logic ov, ov10;
  logic [2:0] ra, ra10;

  always #5 clk = ~clk;

  iq_cic_decimator dut (
    .clk_in(clk), .RST(rst), .in_valid(vld), .rate_log2(rate),
    .I_IN(i_in), .Q_IN(q_in), .I_OUT(i_out), .Q_OUT(q_out),
    .out_valid(ov), .rate_active(ra)
  );

  iq_cic_decimator #(.OUTPUT_WIDTH(10)) dut10 (
    .clk_in(clk), .RST(rst), .in_valid(vld), .rate_log2(rate),
    .I_IN(i_in), .Q_IN(q_in), .I_OUT(i_out10), .Q_OUT(q_out10),
    .out_valid(ov10), .rate_active(ra10)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state: Nth running sums, decimated history, pending outputs.
  typedef struct { int due; longint i12; longint q12; longint i10; longint q10; } pend_t;
  longint cs   [2][N];
  longint hist [2][N+1];
  pend_t  pend [$];
  int     m_cnt, m_rate;
  longint e_i, e_q, e_i10, e_q10;
  logic   e_ov;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic int f_clamp(int r);
    if (r == 0) return 1;
    if (r > 6)  return 6;
    return r;
  endfunction

  function automatic longint f_wrap(longint v);
    longint m;
    m = (longint'(1) << ACCW) - 1;
    v = v & m;
    if (((v >> (ACCW - 1)) & 1) != 0) v = v - (longint'(1) << ACCW);
    return v;
  endfunction

  function automatic longint f_map(longint s, int ow);
    longint v, mx;
    if (ow < IW) v = (s + (longint'(1) << (IW - ow - 1))) >>> (IW - ow);
    else         v = s <<< (ow - IW);
    mx = (longint'(1) << (ow - 1)) - 1;
    if (v > mx)            v = mx;
    else if (v < -mx - 1)  v = -mx - 1;
    return v;
  endfunction

  task automatic model_step();
    longint x, y, c;
    longint r12 [2];
    longint r10 [2];
    pend_t p;
    if (rst) begin
      for (int ch = 0; ch < 2; ch++) begin
        for (int k = 0; k < N; k++)  cs[ch][k] = 0;
        for (int j = 0; j <= N; j++) hist[ch][j] = 0;
      end
      m_cnt = 0; m_rate = f_clamp(int'(rate)); pend.delete();
      e_i = 0; e_q = 0; e_i10 = 0; e_q10 = 0; e_ov = 1'b0;
    end else begin
      e_ov = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        e_i = pend[0].i12; e_q = pend[0].q12; e_i10 = pend[0].i10; e_q10 = pend[0].q10;
        e_ov = 1'b1;
        pend.delete(0);
      end
      if (vld) begin
        for (int ch = 0; ch < 2; ch++) begin
          x = (ch == 0) ? longint'(i_in) : longint'(q_in);
          for (int k = 0; k < N; k++) begin cs[ch][k] += x; x = cs[ch][k]; end
        end
        if (m_cnt == (1 << m_rate) - 1) begin
          for (int ch = 0; ch < 2; ch++) begin
            for (int j = N; j > 0; j--) hist[ch][j] = hist[ch][j-1];
            hist[ch][0] = cs[ch][N-1];
            // Nth backward difference of the decimated Nth running sum
            y = 0; c = 1;
            for (int j = 0; j <= N; j++) begin
              y += ((j % 2) != 0 ? -c : c) * hist[ch][j];
              c = c * (N - j) / (j + 1);
            end
            y = f_wrap(y) >>> (N * m_rate);
            r12[ch] = f_map(y, 12);
            r10[ch] = f_map(y, 10);
          end
          p.due = cyc + N; p.i12 = r12[0]; p.q12 = r12[1]; p.i10 = r10[0]; p.q10 = r10[1];
          pend.push_back(p);
          m_cnt = 0; m_rate = f_clamp(int'(rate));
        end else begin
          m_cnt++;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    model_step();
    chk("out_valid", longint'(ov), longint'(e_ov));
    chk("i_out", longint'(i_out), e_i);
    chk("q_out", longint'(q_out), e_q);
    chk("rate_active", longint'(ra), longint'(m_rate));
    chk("out_valid_w10", longint'(ov10), longint'(e_ov));
    chk("i_out_w10", longint'(i_out10), e_i10);
    chk("q_out_w10", longint'(q_out10), e_q10);
    chk("rate_active_w10", longint'(ra10), longint'(m_rate));
  endtask

  task automatic do_reset(input int r);
    rst = 1'b1; vld = 1'b0; rate = 3'(r);
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    int rate; int iv; int qv; int gap;
    int e_rate; int e_per; int e_i; int e_q; int e_i10; int e_q10;
  } row_t;

  initial begin
    row_t rows [6];
    int   sq [$];
    int   ovs [$];
    int   acc, frames, last_ov, per, lim, phase, rr, lat, rst_cyc, first_ov;
    longint sum;

    rows[0] = '{3, 1000, -1000, 1, 3,  8, 1000, -1000, 250, -250};
    rows[1] = '{2, 2047, -2048, 1, 2,  4, 2047, -2048, 511, -512};
    rows[2] = '{3,  300,  -300, 3, 3, 24,  300,  -300,  75,  -75};
    rows[3] = '{0,  100,     7, 1, 1,  2,  100,     7,  25,    2};
    rows[4] = '{7,   -5,     5, 1, 6, 64,   -5,     5,  -1,    1};
    rows[5] = '{1, -2048, 2047, 2, 1,  4, -2048, 2047, -512,  511};

    // DC vectors: settled value, strobe-to-pulse latency and pulse spacing
    for (int r = 0; r < 6; r++) begin
      do_reset(rows[r].rate);
      rr = 1 << rows[r].e_rate;
      sq.delete();
      acc = 0; frames = 0; last_ov = -1; per = -1; phase = 0; lim = 0;
      i_in = 12'(rows[r].iv); q_in = 12'(rows[r].qv);
      while (frames < 8 && lim < 2500) begin
        vld = (phase % rows[r].gap) == 0;
        phase++; lim++;
        tick();
        if (vld) begin
          acc++;
          if (acc % rr == 0) sq.push_back(cyc);
        end
        if (ov) begin
          lat = (sq.size() > 0) ? cyc - sq.pop_front() + 1 : -1;
          chk("latency", lat, N + 1);
          if (last_ov >= 0) per = cyc - last_ov;
          last_ov = cyc;
          frames++;
        end
      end
      vld = 1'b0;
      chk("dc_frames", frames, 8);
      chk("dc_period", per, rows[r].e_per);
      chk("dc_rate", longint'(ra), rows[r].e_rate);
      chk("dc_i", longint'(i_out), rows[r].e_i);
      chk("dc_q", longint'(q_out), rows[r].e_q);
      chk("dc_i_w10", longint'(i_out10), rows[r].e_i10);
      chk("dc_q_w10", longint'(q_out10), rows[r].e_q10);
    end

    // Rate change mid-frame: current frame completes at R=4, next spans 32
    do_reset(2);
    vld = 1'b1; i_in = 12'sd500; q_in = -12'sd500;
    for (int k = 0; k < 26; k++) tick();
    rate = 3'd5;
    tick();
    chk("rate_hold_mid_frame", longint'(ra), 2);
    tick();
    chk("rate_switch_at_strobe", longint'(ra), 5);
    ovs.delete();
    for (int k = 0; k < 300; k++) begin
      tick();
      if (ov) ovs.push_back(cyc);
    end
    chk("new_rate_period", (ovs.size() >= 2) ? ovs[1] - ovs[0] : -1, 32);
    chk("new_rate_dc_i", longint'(i_out), 500);
    chk("new_rate_dc_q", longint'(q_out), -500);
    chk("new_rate_dc_i_w10", longint'(i_out10), 125);
    chk("new_rate_dc_q_w10", longint'(q_out10), -125);

    // Reset after 5 of 8 samples discards the partial frame
    do_reset(3);
    vld = 1'b1; i_in = 12'sd700; q_in = -12'sd700;
    for (int k = 0; k < 29; k++) tick();
    chk("pre_reset_nonzero", longint'(i_out != 0), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rst_cyc = cyc;
    chk("reset_i", longint'(i_out), 0);
    chk("reset_q", longint'(q_out), 0);
    chk("reset_ov", longint'(ov), 0);
    first_ov = -1;
    for (int k = 0; k < 30; k++) begin
      vld = (k < 8);
      tick();
      if (ov && first_ov < 0) first_ov = cyc;
    end
    vld = 1'b0;
    chk("post_reset_first_pulse", first_ov - rst_cyc, 8 + N);

    // Clamped rate 0 behaves as R=2; one polyphase branch of the impulse
    // response sums to R^(N-1), so unity DC gain leaves x/R in total
    do_reset(0);
    chk("clamp_low_rate", longint'(ra), 1);
    vld = 1'b1; i_in = 12'sd1024; q_in = '0;
    tick();
    i_in = '0;
    sum = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (ov) sum += longint'(i_out);
    end
    chk("impulse_sum", sum, 512);

    // Random samples, gaps, rate changes and resets against the model
    for (int k = 0; k < 3000; k++) begin
      rst  = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 149) == 0) rate = 3'($urandom_range(0, 7));
      vld  = ($urandom_range(0, 9) < 7);
      i_in = 12'($urandom);
      q_in = 12'($urandom);
      tick();
    end
    rst = 1'b0; vld = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog actual=timeout required=finish cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
